pool_window_buffer: RTL and testbench

Upstream feeder for the 2x2 max-pool stage. Accepts a raster-ordered pixel stream (one pixel per cycle, NFMAPS channels of NBITS each), buffers one image row, and emits non-overlapping 2x2 windows (stride 2). The packed output drives the pool stage's valid/input_act pins directly.

---
 rtl/pool_pkg.sv | 30 +++
 rtl/pool_line_buffer.sv | 46 ++++
 rtl/pool_window_buffer.sv | 205 ++++++++++++++++++++
 tb/tb_pool_window_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the 2x2 max-pool window feeder.
//   POOL_KER_SIZE  : pooling kernel edge length
//   POOL_WIN_ELEMS : activations per pooling window
//   pool_elem_e    : position of an element inside a packed window
//   pool_state_e   : row-phase states of the window buffer FSM
// ---------------------------------------------------------------------------
package pool_pkg;

   localparam int POOL_KER_SIZE  = 2;
   localparam int POOL_WIN_ELEMS = POOL_KER_SIZE * POOL_KER_SIZE;

   // Window element order: top-left, top-right, bottom-left, bottom-right
   typedef enum logic [1:0] {
      ELEM_TL = 2'd0,
      ELEM_TR = 2'd1,
      ELEM_BL = 2'd2,
      ELEM_BR = 2'd3
   } pool_elem_e;

   // ROW_TOP fills the line buffer, ROW_BOT pairs with it, DROP_ROW
   // swallows the unpaired last row of an odd-height image
   typedef enum logic [1:0] {
      ROW_TOP  = 2'd0,
      ROW_BOT  = 2'd1,
      DROP_ROW = 2'd2
   } pool_state_e;

endpackage

// File: rtl/pool_line_buffer.sv
// ---------------------------------------------------------------------------
// pool_line_buffer
// One image row of pixel storage for the window feeder.
// Ports:
//   clk          : clock
//   we_i         : write enable
//   wr_addr_i    : column written
//   wr_data_i    : pixel written (all feature maps)
//   rd_addr_a_i  : column of combinational read port A (left column)
//   rd_data_a_o  : pixel stored at rd_addr_a_i
//   rd_addr_b_i  : column of combinational read port B (right column)
//   rd_data_b_o  : pixel stored at rd_addr_b_i
// Contents are deliberately not reset; every entry read is written first.
// ---------------------------------------------------------------------------
module pool_line_buffer
   import pool_pkg::*;
#(
   parameter int PIX_W = 32,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [PIX_W-1:0] wr_data_i,
   input  logic [AW-1:0]    rd_addr_a_i,
   output logic [PIX_W-1:0] rd_data_a_o,
   input  logic [AW-1:0]    rd_addr_b_i,
   output logic [PIX_W-1:0] rd_data_b_o
);

   logic [PIX_W-1:0] mem [DEPTH];

   // Single write port, used only while the top row of a pair streams in
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   // Addresses beyond DEPTH can appear when the caller computes col-1 at
   // column 0 or when DEPTH is not a power of two; return zero there
   assign rd_data_a_o = (int'(rd_addr_a_i) < DEPTH) ? mem[rd_addr_a_i] : '0;
   assign rd_data_b_o = (int'(rd_addr_b_i) < DEPTH) ? mem[rd_addr_b_i] : '0;

endmodule

// File: rtl/pool_window_buffer.sv
// ---------------------------------------------------------------------------
// pool_window_buffer
// Turns a raster pixel stream into non-overlapping 2x2 windows for the
// max-pool stage. The top row of each pair is held in a line buffer; the
// even-column pixel of the bottom row is held in a prev register; the
// window is emitted on the odd-column bottom pixel.
// Ports:
//   clk        : clock
//   rstn       : asynchronous active-low reset
//   in_valid   : pixel accepted this cycle (no backpressure)
//   in_sof     : with in_valid, this pixel is row 0 / col 0
//   in_act     : pixel, fmap i at [i*NBITS +: NBITS]
//   out_valid  : one-cycle pulse, a window is on out_act
//   out_act    : window, fmap i slice at [i*4*NBITS +: 4*NBITS],
//                element k (TL,TR,BL,BR) at [k*NBITS +: NBITS] in the slice
//   frame_done : one-cycle pulse after the last pixel of a frame
//   sof_err    : (only with POOL_WIN_SOF_CHECK_EN) one-cycle pulse after an
//                in_sof away from (0,0) or a (0,0) pixel without in_sof
// Optional build macro: POOL_WIN_SOF_CHECK_EN
// ---------------------------------------------------------------------------
module pool_window_buffer
   import pool_pkg::*;
#(
   parameter int NBITS      = 32,
   parameter int NFMAPS     = 32,
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 8
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               in_valid,
   input  logic                               in_sof,
   input  logic [NBITS*NFMAPS-1:0]            in_act,
   output logic                               out_valid,
   output logic [NBITS*POOL_WIN_ELEMS*NFMAPS-1:0] out_act,
   output logic                               frame_done
`ifdef POOL_WIN_SOF_CHECK_EN
   ,
   output logic                               sof_err
`endif
);

   localparam int PIX_W = NBITS * NFMAPS;
   localparam int WIN_W = NBITS * POOL_WIN_ELEMS * NFMAPS;
   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [ROW_W-1:0] ROW_PENULT = ROW_W'(IMG_HEIGHT - 2);
   localparam bit HEIGHT_ODD = (IMG_HEIGHT % 2) == 1;

   logic [COL_W-1:0] colCnt_q, colCnt_d;
   logic [ROW_W-1:0] rowCnt_q, rowCnt_d;
   pool_state_e      state_q, state_d;
   logic [PIX_W-1:0] prevPix_q, prevPix_d;
   logic             outValid_q, outValid_d;
   logic [WIN_W-1:0] outAct_q, outAct_d;
   logic             frameDone_q, frameDone_d;

   logic [COL_W-1:0] colEff;
   logic [ROW_W-1:0] rowEff;
   pool_state_e      stateEff;
   logic             colLast;
   logic             rowLast;
   logic             lbWe;
   logic [PIX_W-1:0] lbRdLeft;
   logic [PIX_W-1:0] lbRdRight;
   logic [WIN_W-1:0] windowAct;

   // An accepted in_sof relocates the current pixel to (0,0) of a fresh
   // frame, so every decision below works from these effective values
   assign colEff   = in_sof ? '0 : colCnt_q;
   assign rowEff   = in_sof ? '0 : rowCnt_q;
   assign stateEff = in_sof ? ROW_TOP : state_q;
   assign colLast  = (colEff == COL_LAST);
   assign rowLast  = (rowEff == ROW_LAST);

   pool_line_buffer #(
      .PIX_W (PIX_W),
      .DEPTH (IMG_WIDTH),
      .AW    (COL_W)
   ) u_line_buffer (
      .clk         (clk),
      .we_i        (lbWe),
      .wr_addr_i   (colEff),
      .wr_data_i   (in_act),
      .rd_addr_a_i (colEff - COL_W'(1)),
      .rd_data_a_o (lbRdLeft),
      .rd_addr_b_i (colEff),
      .rd_data_b_o (lbRdRight)
   );

   // Assemble the candidate window: top row from the line buffer, bottom
   // left from the prev register, bottom right straight from the input
   always_comb begin
      windowAct = '0;
      for (int i = 0; i < NFMAPS; i++) begin
         windowAct[(i*POOL_WIN_ELEMS + int'(ELEM_TL))*NBITS +: NBITS] = lbRdLeft[i*NBITS +: NBITS];
         windowAct[(i*POOL_WIN_ELEMS + int'(ELEM_TR))*NBITS +: NBITS] = lbRdRight[i*NBITS +: NBITS];
         windowAct[(i*POOL_WIN_ELEMS + int'(ELEM_BL))*NBITS +: NBITS] = prevPix_q[i*NBITS +: NBITS];
         windowAct[(i*POOL_WIN_ELEMS + int'(ELEM_BR))*NBITS +: NBITS] = in_act[i*NBITS +: NBITS];
      end
   end

   // Next-state logic: nothing moves without in_valid. On each accepted
   // pixel the row phase decides whether it is stored, held or paired, and
   // the raster counters advance with the FSM stepping on each row wrap.
   always_comb begin
      colCnt_d    = colCnt_q;
      rowCnt_d    = rowCnt_q;
      state_d     = state_q;
      prevPix_d   = prevPix_q;
      outValid_d  = 1'b0;
      outAct_d    = outAct_q;
      frameDone_d = 1'b0;
      lbWe        = 1'b0;

      if (in_valid) begin
         case (stateEff)
            ROW_TOP: begin
               lbWe = 1'b1;
            end
            ROW_BOT: begin
               // Odd columns are always < IMG_WIDTH, so an odd-width trailing
               // column only ever lands in prev and is never paired
               if (!colEff[0]) begin
                  prevPix_d = in_act;
               end else begin
                  outValid_d = 1'b1;
                  outAct_d   = windowAct;
               end
            end
            default: begin
            end
         endcase

         colCnt_d    = colLast ? '0 : colEff + COL_W'(1);
         rowCnt_d    = rowEff;
         state_d     = stateEff;
         frameDone_d = colLast && rowLast;

         if (colLast) begin
            rowCnt_d = rowLast ? '0 : rowEff + ROW_W'(1);
            case (stateEff)
               ROW_TOP: state_d = ROW_BOT;
               ROW_BOT: state_d = (HEIGHT_ODD && (rowEff == ROW_PENULT)) ? DROP_ROW : ROW_TOP;
               default: state_d = ROW_TOP;
            endcase
         end
      end
   end

`ifdef POOL_WIN_SOF_CHECK_EN
   logic sofErr_q, sofErr_d;

   // Frame alignment check uses the counters as they were before any resync
   always_comb begin
      sofErr_d = 1'b0;
      if (in_valid) begin
         if (in_sof) begin
            sofErr_d = (colCnt_q != '0) || (rowCnt_q != '0);
         end else begin
            sofErr_d = (colCnt_q == '0) && (rowCnt_q == '0);
         end
      end
   end

   // Error flag register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sofErr_q <= 1'b0;
      end else begin
         sofErr_q <= sofErr_d;
      end
   end

   assign sof_err = sofErr_q;
`endif

   // State and output registers; the line buffer is intentionally excluded
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         colCnt_q    <= '0;
         rowCnt_q    <= '0;
         state_q     <= ROW_TOP;
         prevPix_q   <= '0;
         outValid_q  <= 1'b0;
         outAct_q    <= '0;
         frameDone_q <= 1'b0;
      end else begin
         colCnt_q    <= colCnt_d;
         rowCnt_q    <= rowCnt_d;
         state_q     <= state_d;
         prevPix_q   <= prevPix_d;
         outValid_q  <= outValid_d;
         outAct_q    <= outAct_d;
         frameDone_q <= frameDone_d;
      end
   end

   assign out_valid  = outValid_q;
   assign out_act    = outAct_q;
   assign frame_done = frameDone_q;

endmodule

// File: tb/tb_pool_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_pool_window_buffer
// Drives a 4x4 and a 5x5 instance (8-bit activations, 2 feature maps) with
// pattern, negative-value and random frames, gaps, mid-frame resync and
// mid-frame reset. A frame-position model holding the image as a 2D array
// predicts every output cycle by cycle.
// ---------------------------------------------------------------------------
module tb_pool_window_buffer;

   localparam int NB = 8;
   localparam int NF = 2;

   logic        clk;
   logic        rstn;

   logic        inValid4, inSof4, outValid4, frameDone4;
   logic [15:0] inAct4;
   logic [63:0] outAct4;
   logic        inValid5, inSof5, outValid5, frameDone5;
   logic [15:0] inAct5;
   logic [63:0] outAct5;
   logic        sofErr4, sofErr5;

   int testsRun = 0;
   int failures = 0;

   // Reference model state, index 0 = 4x4 instance, 1 = 5x5 instance
   int          dimW [2] = '{4, 5};
   int          dimH [2] = '{4, 5};
   int          mr [2];
   int          mc [2];
   logic [15:0] img [2][5][5];
   logic [63:0] expAct [2];

   pool_window_buffer #(.NBITS(NB), .NFMAPS(NF), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (inValid4),
      .in_sof     (inSof4),
      .in_act     (inAct4),
      .out_valid  (outValid4),
      .out_act    (outAct4),
      .frame_done (frameDone4)
`ifdef POOL_WIN_SOF_CHECK_EN
      ,
      .sof_err    (sofErr4)
`endif
   );

   pool_window_buffer #(.NBITS(NB), .NFMAPS(NF), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (inValid5),
      .in_sof     (inSof5),
      .in_act     (inAct5),
      .out_valid  (outValid5),
      .out_act    (outAct5),
      .frame_done (frameDone5)
`ifdef POOL_WIN_SOF_CHECK_EN
      ,
      .sof_err    (sofErr5)
`endif
   );

`ifndef POOL_WIN_SOF_CHECK_EN
   assign sofErr4 = 1'b0;
   assign sofErr5 = 1'b0;
`endif

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it when observed differs from expected
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Window layout: fmap i slice at i*32, elements TL,TR,BL,BR at 0,8,16,24
   function automatic logic [63:0] packWin(input logic [15:0] tl, input logic [15:0] tr,
                                           input logic [15:0] bl, input logic [15:0] br);
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < NF; i++) begin
         w[i*32 + 0  +: 8] = tl[i*8 +: 8];
         w[i*32 + 8  +: 8] = tr[i*8 +: 8];
         w[i*32 + 16 +: 8] = bl[i*8 +: 8];
         w[i*32 + 24 +: 8] = br[i*8 +: 8];
      end
      return w;
   endfunction

   // mode 0: fmap i = 16r+4c+i, mode 1: random, mode 2: 0x80/0xFF negatives
   function automatic logic [15:0] makePixel(input int mode, input int r, input int c);
      logic [7:0] base;
      base = 8'(16*r + 4*c);
      case (mode)
         0:       return {base + 8'd1, base};
         1:       return 16'($urandom);
         default: return ((r + c) % 2 == 1) ? 16'h80FF : 16'hFF80;
      endcase
   endfunction

   function automatic void modelReset();
      for (int d = 0; d < 2; d++) begin
         mr[d]     = 0;
         mc[d]     = 0;
         expAct[d] = '0;
      end
   endfunction

   // One clock cycle on one instance: drive, predict, clock, compare
   task automatic applyStimulus(input int which, input bit v, input bit s, input logic [15:0] act);
      bit eV, eD, eE;
      int r, c, W, H;
      logic [63:0] oAct;
      logic oV, oD, oE;

      inValid4 = (which == 0) ? v : 1'b0;
      inSof4   = (which == 0) ? s : 1'b0;
      inAct4   = (which == 0) ? act : 16'h0;
      inValid5 = (which == 1) ? v : 1'b0;
      inSof5   = (which == 1) ? s : 1'b0;
      inAct5   = (which == 1) ? act : 16'h0;

      eV = 1'b0; eD = 1'b0; eE = 1'b0;
      W = dimW[which];
      H = dimH[which];
      if (v) begin
         if (s) begin
            eE = (mr[which] != 0) || (mc[which] != 0);
            mr[which] = 0;
            mc[which] = 0;
         end else begin
            eE = (mr[which] == 0) && (mc[which] == 0);
         end
         r = mr[which];
         c = mc[which];
         img[which][r][c] = act;
         // A window closes on the bottom-right pixel of each complete 2x2 block
         if ((r % 2 == 1) && (c % 2 == 1) && (r < 2*(H/2)) && (c < 2*(W/2))) begin
            eV = 1'b1;
            expAct[which] = packWin(img[which][r-1][c-1], img[which][r-1][c],
                                    img[which][r][c-1], img[which][r][c]);
         end
         eD = (r == H-1) && (c == W-1);
         mc[which] = (c == W-1) ? 0 : c + 1;
         if (c == W-1) mr[which] = (r == H-1) ? 0 : r + 1;
      end

      @(posedge clk);
      #1;
      oV   = (which == 0) ? outValid4  : outValid5;
      oD   = (which == 0) ? frameDone4 : frameDone5;
      oAct = (which == 0) ? outAct4    : outAct5;
      oE   = (which == 0) ? sofErr4    : sofErr5;
      checkOutput("out_valid", 64'(oV), 64'(eV));
      checkOutput("frame_done", 64'(oD), 64'(eD));
      checkOutput("out_act", oAct, expAct[which]);
`ifdef POOL_WIN_SOF_CHECK_EN
      checkOutput("sof_err", 64'(oE), 64'(eE));
`else
      if (oE !== 1'b0) checkOutput("sof_err_tied", 64'(oE), 64'(eE));
`endif
   endtask

   // Assert reset with whatever inputs are currently driven; all outputs
   // must clear asynchronously and stay clear across a clock edge
   task automatic applyReset();
      rstn = 1'b0;
      #2;
      for (int k = 0; k < 2; k++) begin
         checkOutput("rst_valid4", 64'(outValid4), 64'd0);
         checkOutput("rst_done4", 64'(frameDone4), 64'd0);
         checkOutput("rst_act4", outAct4, 64'd0);
         checkOutput("rst_valid5", 64'(outValid5), 64'd0);
         checkOutput("rst_act5", outAct5, 64'd0);
`ifdef POOL_WIN_SOF_CHECK_EN
         checkOutput("rst_sof_err4", 64'(sofErr4), 64'd0);
`endif
         if (k == 0) begin
            @(posedge clk);
            #1;
         end
      end
      inValid4 = 1'b0; inSof4 = 1'b0; inAct4 = '0;
      inValid5 = 1'b0; inSof5 = 1'b0; inAct5 = '0;
      modelReset();
      rstn = 1'b1;
   endtask

   // gapMode 0: none, 1: idle cycle before every pixel, 2: random idles
   task automatic sendFrame(input int which, input int mode, input int gapMode, input bit withSof);
      for (int r = 0; r < dimH[which]; r++) begin
         for (int c = 0; c < dimW[which]; c++) begin
            if (gapMode == 1) begin
               applyStimulus(which, 1'b0, 1'b0, 16'h0);
            end else if (gapMode == 2 && $urandom_range(0, 3) == 0) begin
               applyStimulus(which, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
            end
            applyStimulus(which, 1'b1, withSof && r == 0 && c == 0, makePixel(mode, r, c));
         end
      end
   endtask

   // First 'count' raster pixels of a pattern frame, starting with in_sof
   task automatic sendPartial(input int which, input int count);
      for (int n = 0; n < count; n++) begin
         applyStimulus(which, 1'b1, n == 0, makePixel(0, n / dimW[which], n % dimW[which]));
      end
   endtask

   initial begin
      rstn = 1'b1;
      inValid4 = 1'b0; inSof4 = 1'b0; inAct4 = '0;
      inValid5 = 1'b0; inSof5 = 1'b0; inAct5 = '0;
      modelReset();
      #1;
      applyReset();

      // First 4x4 window fmap0 must read TL=00 TR=04 BL=10 BR=14
      sendPartial(0, 6);
      checkOutput("first_window_fmap0", {32'h0, outAct4[31:0]}, 64'h0000_0000_1410_0400);
      for (int n = 6; n < 16; n++) applyStimulus(0, 1'b1, 1'b0, makePixel(0, n / 4, n % 4));

      sendFrame(0, 0, 1, 1'b1);
      sendFrame(1, 0, 0, 1'b1);
      sendFrame(1, 1, 2, 1'b1);

      // Resync at (1,2) of an aborted frame, then a full frame
      sendPartial(0, 6);
      sendFrame(0, 0, 0, 1'b1);

      // Frame without in_sof following a complete frame
      sendFrame(0, 1, 0, 1'b0);

      // Reset while pixel (1,1) is on the inputs, then a clean frame
      sendPartial(0, 5);
      inValid4 = 1'b1; inSof4 = 1'b0; inAct4 = makePixel(0, 1, 1);
      applyReset();
      applyStimulus(0, 1'b0, 1'b0, 16'h0);
      sendFrame(0, 0, 0, 1'b1);

      sendFrame(0, 2, 0, 1'b1);
      sendFrame(1, 2, 2, 1'b1);

      for (int f = 0; f < 8; f++) begin
         sendFrame(f % 2, 1, 2, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
